char_buffer_sequencer: RTL and testbench
========================================

Name: char_buffer_sequencer

Overview:
Command engine in front of the 1920x8 character buffer RAM (24x80, one write port, one registered read port).
- Accepts single-character writes, clear-to-end-of-line, clear-to-end-of-screen and scroll-up commands from the terminal command decoder.
- Sequences the resulting RAM write/read traffic.
- Borrows the RAM read port from the video path only while a scroll is copying.

Parameters:
COLS, 80, characters per line
ROWS, 24, lines per screen
ADDR_BITS, 11, RAM address width (must hold COLS*ROWS-1)
FILL_CHAR, 8'h20, byte written by clears and into the vacated line after a scroll

Ports:
clk  in  1  system clock; all state on rising edge
reset  in  1  asynchronous, active-high reset
cmd_valid  in  1  command request
cmd_ready  out  1  engine can accept a command this cycle
cmd_op  in  3  0=write char, 1=clear EOL, 2=clear EOS, 3=scroll up, 4=scroll down (optional), 5-7 reserved
cmd_row  in  5  row for ops 0-2
cmd_col  in  7  column for ops 0-2
cmd_data  in  8  character for op 0
video_raddr  in  ADDR_BITS  read address requested by the video path
video_stall  out  1  buf_raddr is not video_raddr this cycle; video data is invalid next cycle
buf_raddr  out  ADDR_BITS  RAM read address
buf_dout  in  8  RAM read data; valid the cycle after buf_raddr is presented
buf_waddr  out  ADDR_BITS  RAM write address (registered)
buf_din  out  8  RAM write data (registered)
buf_wen  out  1  RAM write enable (registered)

Behaviour:
- Reset values: state IDLE, cmd_ready=1, buf_wen=0, buf_waddr=0, buf_din=0, video_stall=0. Async reset mid-operation aborts the command immediately; partial clears and scrolls are left as-is.
- Handshake: a command is accepted on a rising edge with cmd_valid&cmd_ready. cmd_ready=1 only in IDLE (combinational from state).
- Address calculation: addr = row*COLS + col, done with shifts/adds ((row<<6)+(row<<4)+col for COLS=80). No divider.
- Op 0, write char:
  - buf_wen=1, buf_waddr=addr, buf_din=cmd_data in the cycle after acceptance.
  - Engine stays in IDLE, so back-to-back writes run at one per cycle.
- Op 1, clear EOL: state CLEAR. One write of FILL_CHAR per cycle, from addr to row*COLS+COLS-1 inclusive; first write the cycle after acceptance. Returns to IDLE after the last write.
- Op 2, clear EOS: same as op 1, with end address COLS*ROWS-1.
- Op 3, scroll up: ignores row/col.
  - State SCROLL: for r = COLS .. COLS*ROWS-1, one per cycle, buf_raddr=r and video_stall=1.
  - The cycle after each read: buf_wen=1, buf_waddr=r-COLS, buf_din=buf_dout.
  - State DRAIN, 1 cycle: last copy write, video_stall=0.
  - State CLEAR over the last row (COLS*(ROWS-1) .. COLS*ROWS-1).
  - Total busy for defaults: 1840+1+80 = 1921 cycles after acceptance. cmd_ready=1 again the cycle after the final write.
- buf_raddr = video_raddr whenever not in SCROLL. This mux is combinational, so the video path sees no added latency.
- Ignored commands: row>=ROWS or col>=COLS on ops 0-2, and reserved ops. These are accepted (handshake completes), produce no writes and leave the engine in IDLE.
- Clears and scrolls never wrap past COLS*ROWS-1.
- cmd_valid held during busy has no effect. The command is taken on the first cycle back in IDLE.

Optional Feature:
Macro CHARSEQ_SCROLL_DOWN_EN.
- Defined, op 4 = scroll down (VT52 reverse line feed at the top line):
  - Reads r = COLS*ROWS-COLS-1 down to 0.
  - Writes r+COLS one cycle after each read.
  - DRAIN cycle, then clears row 0 (addresses 0..COLS-1).
  - Same 1921-cycle busy time and video_stall timing as scroll up.
- Undefined: op 4 is treated as reserved (accepted, ignored).

Test Plan:
- Op0 row=2 col=5 data=0x41 -> next cycle buf_wen=1, waddr=165, din=0x41; cmd_ready stays 1; 3 back-to-back writes -> 3 consecutive wen cycles.
- Op1 row=23 col=78 -> wen for exactly 2 cycles, waddr 1918 then 1919, din=0x20; cmd_ready low 2 cycles.
- Op2 row=0 col=0 -> 1920 writes of 0x20 at addresses 0..1919 in order; RAM model all spaces afterwards.
- RAM preloaded with byte=row index; op3 -> row k holds k+1 for k<23, row 23 all 0x20; busy exactly 1921 cycles; video_stall high exactly 1840 cycles; buf_raddr=video_raddr otherwise.
- Op0 with row=24 and op=6 -> accepted, no wen; reset asserted at cycle 500 of a scroll -> wen=0 and cmd_ready=1 immediately, rows 0..5 already shifted.
- With CHARSEQ_SCROLL_DOWN_EN, op4 on row-indexed RAM -> row k holds k-1 for k>=1, row 0 all 0x20. Without the macro -> no writes.

Source files
------------

// File: rtl/char_buffer_sequencer.sv
// Purpose : command engine in front of the 24x80 character RAM. It handles write-char,
//           clear-EOL, clear-EOS and scroll-up commands, and scroll-down when the
//           CHARSEQ_SCROLL_DOWN_EN macro is defined.
// Latency : a write or the first clear write appears the cycle after acceptance;
//           a scroll keeps the engine busy for COLS*ROWS+1 cycles.
// Backpr. : cmd_ready is high only in IDLE. While the engine is busy, cmd_valid waits.
// Ports   : clk/reset (async, active-high); cmd_* command handshake from the decoder;
//           video_raddr/video_stall carry the video read path; buf_* drive the RAM ports.
// Config  : `define CHARSEQ_SCROLL_DOWN_EN enables op 4 (scroll down). Without it,
//           op 4 is accepted and ignored.
module char_buffer_sequencer #(
   parameter int               COLS      = 80,
   parameter int               ROWS      = 24,
   parameter int               ADDR_BITS = 11,
   parameter logic [7:0]       FILL_CHAR = 8'h20
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 cmd_valid,
   output logic                 cmd_ready,
   input  logic [2:0]           cmd_op,
   input  logic [4:0]           cmd_row,
   input  logic [6:0]           cmd_col,
   input  logic [7:0]           cmd_data,
   input  logic [ADDR_BITS-1:0] video_raddr,
   output logic                 video_stall,
   output logic [ADDR_BITS-1:0] buf_raddr,
   input  logic [7:0]           buf_dout,
   output logic [ADDR_BITS-1:0] buf_waddr,
   output logic [7:0]           buf_din,
   output logic                 buf_wen
);

   localparam logic [ADDR_BITS-1:0] L_COLS     = ADDR_BITS'(COLS);
   localparam logic [ADDR_BITS-1:0] L_COLS_M1  = ADDR_BITS'(COLS - 1);
   localparam logic [ADDR_BITS-1:0] L_LAST     = ADDR_BITS'(COLS * ROWS - 1);
   localparam logic [ADDR_BITS-1:0] L_LAST_ROW = ADDR_BITS'(COLS * (ROWS - 1));
   localparam logic [4:0]           L_ROWS5    = 5'(ROWS);
   localparam logic [6:0]           L_COLS7    = 7'(COLS);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_CLEAR  = 2'd1,
      S_SCROLL = 2'd2,
      S_DRAIN  = 2'd3
   } state_t;

   state_t                 r_state;
   logic                   r_wen;
   logic [ADDR_BITS-1:0]   r_waddr;
   logic [7:0]             r_din;
   logic                   r_copy;   // current write is a scroll copy: data comes from the RAM
   logic [ADDR_BITS-1:0]   r_end;    // last address of the running clear
   logic [ADDR_BITS-1:0]   r_rd;     // scroll read pointer
   logic                   r_dir;    // 0 = scroll up, 1 = scroll down

   logic [ADDR_BITS-1:0]   w_row;
   logic [ADDR_BITS-1:0]   w_col;
   logic [ADDR_BITS-1:0]   w_row_base;
   logic [ADDR_BITS-1:0]   w_addr;
   logic [ADDR_BITS-1:0]   w_eol;
   logic [ADDR_BITS-1:0]   w_scroll_end;
   logic                   w_in_range;
   logic                   w_accept;

   assign w_row = {{(ADDR_BITS-5){1'b0}}, cmd_row};
   assign w_col = {{(ADDR_BITS-7){1'b0}}, cmd_col};

   // For 80 columns, row*80 = row*64 + row*16. This avoids a general multiplier.
   assign w_row_base = (COLS == 80) ? ((w_row << 6) + (w_row << 4)) : (w_row * L_COLS);
   assign w_addr     = w_row_base + w_col;
   assign w_eol      = w_row_base + L_COLS_M1;
   assign w_in_range = (cmd_row < L_ROWS5) && (cmd_col < L_COLS7);

   assign cmd_ready = (r_state == S_IDLE);
   assign w_accept  = cmd_valid && cmd_ready;

   // The read port belongs to the video path except while a scroll is copying.
   assign video_stall  = (r_state == S_SCROLL);
   assign buf_raddr    = video_stall ? r_rd : video_raddr;
   assign w_scroll_end = r_dir ? '0 : L_LAST;

   // Copy writes take their data straight from the RAM read register, so the
   // write lands the cycle after its read with no extra pipeline stage.
   assign buf_wen   = r_wen;
   assign buf_waddr = r_waddr;
   assign buf_din   = r_copy ? buf_dout : r_din;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= S_IDLE;
         r_wen   <= 1'b0;
         r_waddr <= '0;
         r_din   <= 8'h00;
         r_copy  <= 1'b0;
         r_end   <= '0;
         r_rd    <= '0;
         r_dir   <= 1'b0;
      end else begin
         r_wen  <= 1'b0;
         r_copy <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (w_accept) begin
                  case (cmd_op)
                     3'd0: begin
                        if (w_in_range) begin
                           r_wen   <= 1'b1;
                           r_waddr <= w_addr;
                           r_din   <= cmd_data;
                        end
                     end
                     3'd1, 3'd2: begin
                        if (w_in_range) begin
                           r_wen   <= 1'b1;
                           r_waddr <= w_addr;
                           r_din   <= FILL_CHAR;
                           r_end   <= (cmd_op == 3'd1) ? w_eol : L_LAST;
                           r_state <= S_CLEAR;
                        end
                     end
                     3'd3: begin
                        r_rd    <= L_COLS;
                        r_dir   <= 1'b0;
                        r_state <= S_SCROLL;
                     end
`ifdef CHARSEQ_SCROLL_DOWN_EN
                     3'd4: begin
                        r_rd    <= L_LAST_ROW - 1'b1;
                        r_dir   <= 1'b1;
                        r_state <= S_SCROLL;
                     end
`endif
                     default: ;  // reserved: accepted, no effect
                  endcase
               end
            end
            S_CLEAR: begin
               // r_waddr is the clear pointer; the write for r_end is already on the port.
               if (r_waddr == r_end) begin
                  r_state <= S_IDLE;
               end else begin
                  r_wen   <= 1'b1;
                  r_waddr <= r_waddr + 1'b1;
               end
            end
            S_SCROLL: begin
               r_wen   <= 1'b1;
               r_copy  <= 1'b1;
               r_waddr <= r_dir ? (r_rd + L_COLS) : (r_rd - L_COLS);
               if (r_rd == w_scroll_end) begin
                  r_state <= S_DRAIN;
               end else begin
                  r_rd <= r_dir ? (r_rd - 1'b1) : (r_rd + 1'b1);
               end
            end
            S_DRAIN: begin
               // The last copy write is on the port now. Next comes the line
               // vacated by the scroll.
               r_wen   <= 1'b1;
               r_din   <= FILL_CHAR;
               r_waddr <= r_dir ? '0 : L_LAST_ROW;
               r_end   <= r_dir ? L_COLS_M1 : L_LAST;
               r_state <= S_CLEAR;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_char_buffer_sequencer.sv
// Purpose : self-checking bench for char_buffer_sequencer with a behavioural RAM and a write scoreboard.
// Latency : not applicable (bench).
// Backpr. : commands wait for cmd_ready with a bounded cycle budget.
module tb_char_buffer_sequencer;

   typedef struct packed {
      logic [10:0] a;
      logic [7:0]  d;
   } wr_t;

   logic        clk;
   logic        reset;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [2:0]  cmd_op;
   logic [4:0]  cmd_row;
   logic [6:0]  cmd_col;
   logic [7:0]  cmd_data;
   logic [10:0] video_raddr;
   logic        video_stall;
   logic [10:0] buf_raddr;
   logic [7:0]  buf_dout;
   logic [10:0] buf_waddr;
   logic [7:0]  buf_din;
   logic        buf_wen;

   logic [7:0]  mem [0:1919];
   logic        preload;
   logic        sb_en;
   wr_t         exp_q[$];
   int          checks;
   int          errors;
   int          wr_cnt;

   char_buffer_sequencer dut (
      .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_op(cmd_op), .cmd_row(cmd_row), .cmd_col(cmd_col), .cmd_data(cmd_data),
      .video_raddr(video_raddr), .video_stall(video_stall), .buf_raddr(buf_raddr),
      .buf_dout(buf_dout), .buf_waddr(buf_waddr), .buf_din(buf_din), .buf_wen(buf_wen)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, got timeout required finish");
      $fatal(1);
   end

   // The video address walks the screen continuously so that mux errors show up.
   initial begin
      video_raddr = 11'd0;
      forever begin
         @(posedge clk);
         #2;
         video_raddr = (video_raddr == 11'd1919) ? 11'd0 : video_raddr + 11'd1;
      end
   end

   // RAM model: one write port and a registered read port. Preload fills each row with its row index.
   always @(posedge clk) begin
      if (preload) begin
         for (int i = 0; i < 1920; i++) mem[i] <= 8'(i / 80);
      end else if (buf_wen && buf_waddr < 11'd1920) begin
         mem[buf_waddr] <= buf_din;
      end
      buf_dout <= mem[buf_raddr];
   end

   task automatic chk(input string name, input int act, input int exp_v);
      checks++;
      if (act != exp_v) begin
         errors++;
         $display("FAIL %s: got %0d required %0d", name, act, exp_v);
      end
   endtask

   // Monitor pops one expected write for every write the DUT presents.
   always @(negedge clk) begin
      wr_t e;
      if (buf_wen) wr_cnt++;
      if (buf_wen && sb_en) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_write_addr", int'(buf_waddr), -1);
         end else begin
            e = exp_q.pop_front();
            chk("wr_addr", int'(buf_waddr), int'(e.a));
            chk("wr_data", int'(buf_din), int'(e.d));
         end
      end
   end

   task automatic push(input int a, input int d);
      wr_t e;
      e.a = 11'(a);
      e.d = 8'(d);
      exp_q.push_back(e);
   endtask

   // Called at a negedge. Returns at the negedge after the accepting edge.
   task automatic send(input logic [2:0] op, input logic [4:0] row, input logic [6:0] col,
                       input logic [7:0] dat);
      int n = 0;
      while (!cmd_ready && n < 5000) begin
         @(negedge clk);
         n++;
      end
      if (!cmd_ready) chk("send_ready_timeout", 0, 1);
      cmd_valid = 1'b1;
      cmd_op    = op;
      cmd_row   = row;
      cmd_col   = col;
      cmd_data  = dat;
      @(negedge clk);
      cmd_valid = 1'b0;
   endtask

   task automatic run_busy(output int busy, output int stalls, output int vmis);
      busy = 0;
      stalls = 0;
      vmis = 0;
      while (!cmd_ready && busy < 4000) begin
         busy++;
         if (video_stall) stalls++;
         else if (buf_raddr != video_raddr) vmis++;
         @(negedge clk);
      end
   endtask

   task automatic do_preload();
      preload = 1'b1;
      @(negedge clk);
      preload = 1'b0;
      @(negedge clk);
   endtask

   initial begin
      int busy, stalls, vmis, w0, bad, expv;
      checks = 0; errors = 0; wr_cnt = 0;
      reset = 1'b1; cmd_valid = 1'b0; cmd_op = 3'd0; cmd_row = 5'd0; cmd_col = 7'd0;
      cmd_data = 8'h00; preload = 1'b0; sb_en = 1'b1;
      repeat (3) @(negedge clk);
      chk("reset_cmd_ready", int'(cmd_ready), 1);
      chk("reset_wen", int'(buf_wen), 0);
      chk("reset_waddr", int'(buf_waddr), 0);
      chk("reset_din", int'(buf_din), 0);
      chk("reset_stall", int'(video_stall), 0);
      reset = 1'b0;
      @(negedge clk);

      // Single write, then three back-to-back writes.
      push(165, 8'h41);
      send(3'd0, 5'd2, 7'd5, 8'h41);
      chk("op0_wen", int'(buf_wen), 1);
      chk("op0_ready", int'(cmd_ready), 1);
      @(negedge clk);
      push(0, 8'h61); push(1, 8'h62); push(1919, 8'h63);
      send(3'd0, 5'd0, 7'd0, 8'h61);
      chk("b2b_wen1", int'(buf_wen), 1);
      send(3'd0, 5'd0, 7'd1, 8'h62);
      chk("b2b_wen2", int'(buf_wen), 1);
      send(3'd0, 5'd23, 7'd79, 8'h63);
      chk("b2b_wen3", int'(buf_wen), 1);
      chk("b2b_ready", int'(cmd_ready), 1);
      @(negedge clk);
      chk("b2b_idle_wen", int'(buf_wen), 0);

      // Clear to the end of line near the bottom-right corner.
      w0 = wr_cnt;
      push(1918, 8'h20); push(1919, 8'h20);
      send(3'd1, 5'd23, 7'd78, 8'h00);
      run_busy(busy, stalls, vmis);
      chk("eol_busy", busy, 2);
      chk("eol_writes", wr_cnt - w0, 2);
      chk("eol_sb_empty", exp_q.size(), 0);

      // Clear the whole screen.
      for (int a = 0; a < 1920; a++) push(a, 8'h20);
      send(3'd2, 5'd0, 7'd0, 8'h00);
      run_busy(busy, stalls, vmis);
      chk("eos_busy", busy, 1920);
      chk("eos_sb_empty", exp_q.size(), 0);
      bad = 0;
      for (int a = 0; a < 1920; a++) if (mem[a] != 8'h20) bad++;
      chk("eos_ram_bad", bad, 0);

      // Scroll up on a row-indexed screen.
      do_preload();
      for (int a = 0; a < 1840; a++) push(a, a / 80 + 1);
      for (int a = 1840; a < 1920; a++) push(a, 8'h20);
      send(3'd3, 5'd0, 7'd0, 8'h00);
      run_busy(busy, stalls, vmis);
      chk("scroll_busy", busy, 1921);
      chk("scroll_stall_cycles", stalls, 1840);
      chk("scroll_video_mux_errors", vmis, 0);
      chk("scroll_sb_empty", exp_q.size(), 0);
      bad = 0;
      for (int a = 0; a < 1920; a++) begin
         expv = (a < 1840) ? (a / 80 + 1) : 32;
         if (int'(mem[a]) != expv) bad++;
      end
      chk("scroll_ram_bad", bad, 0);
      chk("after_scroll_raddr_mux", int'(buf_raddr), int'(video_raddr));

      // Ignored commands: out-of-range row/col and a reserved op.
      w0 = wr_cnt;
      send(3'd0, 5'd24, 7'd3, 8'h55);
      chk("ign_row_ready", int'(cmd_ready), 1);
      send(3'd6, 5'd1, 7'd1, 8'h55);
      chk("ign_op6_ready", int'(cmd_ready), 1);
      send(3'd1, 5'd1, 7'd80, 8'h00);
      chk("ign_col_ready", int'(cmd_ready), 1);
      repeat (2) @(negedge clk);
      chk("ign_writes", wr_cnt - w0, 0);

      // Scroll down (or reserved op 4 if the feature is built out).
      do_preload();
      w0 = wr_cnt;
`ifdef CHARSEQ_SCROLL_DOWN_EN
      for (int r = 1839; r >= 0; r--) push(r + 80, r / 80);
      for (int a = 0; a < 80; a++) push(a, 8'h20);
      send(3'd4, 5'd0, 7'd0, 8'h00);
      run_busy(busy, stalls, vmis);
      chk("sdown_busy", busy, 1921);
      chk("sdown_stall_cycles", stalls, 1840);
      chk("sdown_video_mux_errors", vmis, 0);
      chk("sdown_sb_empty", exp_q.size(), 0);
      bad = 0;
      for (int a = 0; a < 1920; a++) begin
         expv = (a < 80) ? 32 : (a / 80 - 1);
         if (int'(mem[a]) != expv) bad++;
      end
      chk("sdown_ram_bad", bad, 0);
`else
      send(3'd4, 5'd0, 7'd0, 8'h00);
      run_busy(busy, stalls, vmis);
      chk("op4_reserved_busy", busy, 0);
      repeat (2) @(negedge clk);
      chk("op4_reserved_writes", wr_cnt - w0, 0);
`endif

      // Reset in the middle of a scroll.
      do_preload();
      sb_en = 1'b0;
      send(3'd3, 5'd0, 7'd0, 8'h00);
      repeat (499) @(negedge clk);
      chk("mid_scroll_stall", int'(video_stall), 1);
      reset = 1'b1;
      #1;
      chk("abort_wen", int'(buf_wen), 0);
      chk("abort_ready", int'(cmd_ready), 1);
      chk("abort_stall", int'(video_stall), 0);
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      bad = 0;
      for (int a = 0; a < 480; a++) if (int'(mem[a]) != a / 80 + 1) bad++;
      chk("abort_rows0_5_bad", bad, 0);
      chk("abort_row23_untouched", int'(mem[1900]), 23);
      sb_en = 1'b1;
      chk("final_sb_empty", exp_q.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
